// File: rtl/path_addr_gen.sv
// ORAM path address generator: walks the root-leaf bucket path in either direction, one DRAM command per burst.
// Optional perf counters (StallCnt/CmdCnt) are built only when PATH_ADDR_GEN_PERF_EN is defined.
module path_addr_gen #(
  parameter int unsigned ORAML      = 31,
  parameter int unsigned BKT_BURSTS = 4,
  parameter int unsigned HDR_BURSTS = 1,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned NCH        = 1,
  parameter int unsigned DDR_AW     = 28,
  parameter int unsigned CMD_W      = 3,
  localparam int unsigned LW        = $clog2(ORAML + 2),
  localparam int unsigned CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              RWIn,
  input  logic              BHIn,
  input  logic              DirIn,
  input  logic [ORAML-1:0]  Leaf,
  output logic              Ready,
  input  logic              CmdReady,
  output logic              CmdValid,
  output logic [CMD_W-1:0]  Cmd,
  output logic [CHW-1:0]    Chan,
  output logic [DDR_AW-1:0] Addr,
  output logic [ORAML:0]    BktIdx,
  output logic [LW-1:0]     Level,
  output logic              Last,
  output logic [31:0]       StallCnt,
  output logic [31:0]       CmdCnt
);

  localparam int unsigned BW      = (BKT_BURSTS > 1) ? $clog2(BKT_BURSTS) : 1;
  localparam int unsigned NCH_LOG = $clog2(NCH);
  localparam int unsigned IW      = ORAML + 2;
  localparam logic [CMD_W-1:0] CMD_RD = CMD_W'(1);
  localparam logic [CMD_W-1:0] CMD_WR = '0;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state, state_n;
  logic             rw_q, rw_n, bh_q, bh_n, dir_q, dir_n;
  logic [ORAML-1:0] leaf_q, leaf_n;
  logic [LW-1:0]    level_q, level_n;
  logic [BW-1:0]    burst_q, burst_n;

  logic             fire, burst_last, level_last;
  logic [BW-1:0]    nb_m1;
  logic [LW-1:0]    shamt;
  logic [IW-1:0]    pow2, leaf_shift, bkt_full, local_idx;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      rw_q    <= 1'b0;
      bh_q    <= 1'b0;
      dir_q   <= 1'b0;
      leaf_q  <= '0;
      level_q <= '0;
      burst_q <= '0;
    end else begin
      state   <= state_n;
      rw_q    <= rw_n;
      bh_q    <= bh_n;
      dir_q   <= dir_n;
      leaf_q  <= leaf_n;
      level_q <= level_n;
      burst_q <= burst_n;
    end
  end

  assign nb_m1      = bh_q ? BW'(HDR_BURSTS - 1) : BW'(BKT_BURSTS - 1);
  assign burst_last = (burst_q == nb_m1);
  assign level_last = dir_q ? (level_q == '0) : (level_q == LW'(ORAML));
  assign fire       = CmdValid && CmdReady;

  always_comb begin
    state_n = state;
    rw_n    = rw_q;
    bh_n    = bh_q;
    dir_n   = dir_q;
    leaf_n  = leaf_q;
    level_n = level_q;
    burst_n = burst_q;
    unique case (state)
      IDLE: begin
        if (Start) begin
          rw_n    = RWIn;
          bh_n    = BHIn;
          dir_n   = DirIn;
          leaf_n  = Leaf;
          level_n = DirIn ? LW'(ORAML) : '0;
          burst_n = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (fire) begin
          if (burst_last) begin
            burst_n = '0;
            if (level_last)
              state_n = IDLE;
            else
              level_n = dir_q ? level_q - LW'(1) : level_q + LW'(1);
          end else begin
            burst_n = burst_q + BW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Heap index of the bucket on this leaf's path at the current level, kept one bit wider than the output.
  always_comb begin
    pow2          = '0;
    pow2[level_q] = 1'b1;
    shamt         = LW'(ORAML) - level_q;
    leaf_shift    = {2'b00, leaf_q} >> shamt;
    bkt_full      = pow2 - IW'(1) + leaf_shift;
    local_idx     = bkt_full >> NCH_LOG;
  end

  assign Ready    = (state == IDLE);
  assign CmdValid = (state == ISSUE);
  assign Last     = CmdValid && burst_last && level_last;
  assign Cmd      = rw_q ? CMD_RD : CMD_WR;
  assign Level    = level_q;
  assign BktIdx   = bkt_full[ORAML:0];
  assign Chan     = (NCH > 1) ? bkt_full[CHW-1:0] : '0;
  // Headers share the full-bucket stride so header and body of a bucket stay co-located.
  assign Addr     = (DDR_AW'(local_idx) * DDR_AW'(BKT_BURSTS) + DDR_AW'(burst_q)) * DDR_AW'(BURST_LEN);

`ifdef PATH_ADDR_GEN_PERF_EN
  logic [31:0] stall_q, cnt_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      stall_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (CmdValid && !CmdReady && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      if (fire && cnt_q != '1)
        cnt_q <= cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_q;
  assign CmdCnt   = cnt_q;
`else
  assign StallCnt = '0;
  assign CmdCnt   = '0;
`endif

endmodule

// File: tb/tb_path_addr_gen.sv
// Self-checking bench for path_addr_gen: path-walk reference model plus directed literal checks and random traffic.
module tb_path_addr_gen;

  localparam int unsigned ORAML = 3;
`ifdef PATH_ADDR_GEN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, start, rw, bh, dir, cmd_ready;
  logic [ORAML-1:0] leaf;

  logic ready1, valid1, last1, ready2, valid2, last2;
  logic [2:0] cmd1, cmd2, level1, level2;
  logic [0:0] chan1, chan2;
  logic [27:0] addr1, addr2;
  logic [3:0] bkt1, bkt2;
  logic [31:0] stall1, cnt1, stall2, cnt2;

  path_addr_gen #(.ORAML(ORAML), .BKT_BURSTS(4), .HDR_BURSTS(1), .BURST_LEN(8), .NCH(1), .DDR_AW(28), .CMD_W(3)) dut1 (
    .Clock(clock), .Reset(reset), .Start(start), .RWIn(rw), .BHIn(bh), .DirIn(dir), .Leaf(leaf),
    .Ready(ready1), .CmdReady(cmd_ready), .CmdValid(valid1), .Cmd(cmd1), .Chan(chan1), .Addr(addr1),
    .BktIdx(bkt1), .Level(level1), .Last(last1), .StallCnt(stall1), .CmdCnt(cnt1));

  path_addr_gen #(.ORAML(ORAML), .BKT_BURSTS(4), .HDR_BURSTS(1), .BURST_LEN(8), .NCH(2), .DDR_AW(28), .CMD_W(3)) dut2 (
    .Clock(clock), .Reset(reset), .Start(start), .RWIn(rw), .BHIn(bh), .DirIn(dir), .Leaf(leaf),
    .Ready(ready2), .CmdReady(cmd_ready), .CmdValid(valid2), .Cmd(cmd2), .Chan(chan2), .Addr(addr2),
    .BktIdx(bkt2), .Level(level2), .Last(last2), .StallCnt(stall2), .CmdCnt(cnt2));

  typedef struct { int unsigned bkt; int unsigned lvl; int unsigned b; bit last; bit rd; } exp_t;
  typedef struct { int unsigned bkt; int unsigned addr1; int unsigned chan2; int unsigned addr2; int unsigned lvl; int unsigned cmd; } log_t;

  exp_t exp_q[$];
  log_t log_q[$];
  bit busy = 1'b0, armed = 1'b0;
  int unsigned exp_stall = 0, exp_cnt = 0;
  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected command list for one request: descend the heap from the root, choosing children from leaf bits.
  task automatic build(input bit r, input bit h, input bit d, input int unsigned lf);
    int unsigned node[ORAML+1];
    int unsigned nb = h ? 1 : 4;
    node[0] = 0;
    for (int l = 1; l <= ORAML; l++)
      node[l] = 2 * node[l-1] + 1 + ((lf >> (ORAML - l)) & 1);
    for (int i = 0; i <= ORAML; i++) begin
      int unsigned l = d ? ORAML - i : i;
      for (int unsigned b = 0; b < nb; b++) begin
        exp_t e;
        e.bkt = node[l]; e.lvl = l; e.b = b; e.rd = r;
        e.last = (i == ORAML) && (b == nb - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic int unsigned exp_addr(input int unsigned bkt, input int unsigned b, input int unsigned nch);
    return ((bkt / nch * 4 + b) * 8) & 32'h0FFF_FFFF;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    log_t lg;
    if (armed) begin
      chk("ready", ready1, !busy);
      chk("valid", valid1, busy);
      chk("ready2", ready2, !busy);
      chk("valid2", valid2, busy);
      chk("stallcnt", stall1, PERF ? exp_stall : 0);
      chk("cmdcnt", cnt1, PERF ? exp_cnt : 0);
      if (busy) begin
        e = exp_q[0];
        chk("level", level1, e.lvl);
        chk("bktidx", bkt1, e.bkt);
        chk("addr", addr1, exp_addr(e.bkt, e.b, 1));
        chk("chan", chan1, 0);
        chk("last", last1, e.last);
        chk("cmd", cmd1, e.rd ? 1 : 0);
        chk("bktidx2", bkt2, e.bkt);
        chk("chan2", chan2, e.bkt % 2);
        chk("addr2", addr2, exp_addr(e.bkt, e.b, 2));
        chk("last2", last2, e.last);
      end else begin
        chk("last_idle", last1, 0);
      end
    end
    if (reset) begin
      exp_q.delete();
      busy = 1'b0; exp_stall = 0; exp_cnt = 0; armed = 1'b1;
    end else if (busy) begin
      if (cmd_ready) begin
        lg.bkt = bkt1; lg.addr1 = addr1; lg.chan2 = chan2; lg.addr2 = addr2; lg.lvl = level1; lg.cmd = cmd1;
        log_q.push_back(lg);
        void'(exp_q.pop_front());
        exp_cnt++;
        if (exp_q.size() == 0) busy = 1'b0;
      end else begin
        exp_stall++;
      end
    end else if (start) begin
      build(rw, bh, dir, leaf);
      busy = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      cyc();
      if (ready1 && !valid1) done = 1'b1;
    end
    chk("idle_timeout", done, 1);
  endtask

  task automatic launch(input bit r, input bit h, input bit d, input logic [ORAML-1:0] lf);
    rw = r; bh = h; dir = d; leaf = lf; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rw = 1'b0; bh = 1'b0; dir = 1'b0; leaf = '0; cmd_ready = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    chk("reset_ready", ready1, 1);
    chk("reset_valid", valid1, 0);
    chk("reset_level", level1, 0);

    // Read, header-only, root to leaf, leaf 5; the NCH=2 instance covers channel interleave.
    log_q.delete();
    launch(1, 1, 0, 3'd5);
    wait_idle();
    chk("t1_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t1_bkt0", log_q[0].bkt, 0);   chk("t1_bkt1", log_q[1].bkt, 2);
      chk("t1_bkt2", log_q[2].bkt, 5);   chk("t1_bkt3", log_q[3].bkt, 12);
      chk("t1_addr0", log_q[0].addr1, 0);  chk("t1_addr1", log_q[1].addr1, 64);
      chk("t1_addr2", log_q[2].addr1, 160); chk("t1_addr3", log_q[3].addr1, 384);
      chk("t1_cmd", log_q[0].cmd, 1);
      chk("t4_chan2", log_q[2].chan2, 1);  chk("t4_chan3", log_q[3].chan2, 0);
      chk("t4_addr1", log_q[1].addr2, 32); chk("t4_addr3", log_q[3].addr2, 192);
    end

    // Write, full bucket, root to leaf.
    log_q.delete();
    launch(0, 0, 0, 3'd5);
    wait_idle();
    chk("t2_count", log_q.size(), 16);
    if (log_q.size() == 16) begin
      chk("t2_addr1", log_q[1].addr1, 8);   chk("t2_addr3", log_q[3].addr1, 24);
      chk("t2_addr4", log_q[4].addr1, 64);  chk("t2_addr15", log_q[15].addr1, 408);
      chk("t2_lvl3", log_q[3].lvl, 0);      chk("t2_lvl4", log_q[4].lvl, 1);
      chk("t2_cmd", log_q[0].cmd, 0);
    end

    // Leaf to root.
    log_q.delete();
    launch(1, 1, 1, 3'd5);
    wait_idle();
    chk("t3_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t3_bkt0", log_q[0].bkt, 12);    chk("t3_bkt3", log_q[3].bkt, 0);
      chk("t3_addr0", log_q[0].addr1, 384); chk("t3_addr1", log_q[1].addr1, 160);
      chk("t3_lvl0", log_q[0].lvl, 3);
    end

    // Backpressure for three cycles mid-path.
    do_reset();
    launch(1, 1, 0, 3'd5);
    cyc(); cyc();
    cmd_ready = 1'b0;
    cyc(); cyc(); cyc();
    cmd_ready = 1'b1;
    wait_idle();
    chk("t5_stall", stall1, PERF ? 3 : 0);
    chk("t5_cmdcnt", cnt1, PERF ? 4 : 0);

    // Start ignored while issuing, then reset aborts the path.
    do_reset();
    log_q.delete();
    launch(0, 0, 0, 3'd6);
    cyc(); cyc();
    launch(1, 1, 1, 3'd1);
    chk("t6_still_busy", valid1, 1);
    chk("t6_level", level1, 0);
    chk("t6_fired", log_q.size(), 3);
    do_reset();
    chk("t6_ready", ready1, 1);
    chk("t6_valid", valid1, 0);
    log_q.delete();
    launch(1, 1, 0, 3'd6);
    wait_idle();
    chk("t6_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chk("t6_first_lvl", log_q[0].lvl, 0);
      chk("t6_first_bkt", log_q[0].bkt, 0);
      chk("t6_last_bkt", log_q[3].bkt, 13);
    end

    // Random traffic: spurious starts, backpressure and occasional resets.
    for (int i = 0; i < 2000; i++) begin
      start     = ($urandom % 3) == 0;
      rw        = $urandom % 2;
      bh        = $urandom % 2;
      dir       = $urandom % 2;
      leaf      = 3'($urandom);
      cmd_ready = ($urandom % 4) != 0;
      reset     = ($urandom % 300) == 0;
      cyc();
    end
    reset = 1'b0; start = 1'b0; cmd_ready = 1'b1;
    wait_idle();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
